logic_unit_seq: RTL and testbench

Parametrised sequential bitwise logic unit. It generalises the combinational 8-bit AND slice to WIDTH-bit operands and eight logic operations. Operands are processed SLICE bits per clock under a start/busy/done handshake. It sits beside the adder/ALU datapath blocks and returns a registered result plus a zero flag.

---
 rtl/logic_unit_seq_if.sv | 17 +
 rtl/logic_unit_seq.sv | 109 ++++++++++
 tb/tb_logic_unit_seq.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/logic_unit_seq_if.sv
// Request/response bundle for the sequential logic unit.
// The master side drives the operation; the slave side returns status and result.
interface logic_unit_seq_if #(
   parameter int WIDTH = 8
);
   logic             start;
   logic [2:0]       op;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] result;
   logic             zero;

   modport master (output start, op, a, b, input busy, done, result, zero);
   modport slave  (input start, op, a, b, output busy, done, result, zero);
endinterface

// File: rtl/logic_unit_seq.sv
// Sequential bitwise logic unit: WIDTH-bit operands, SLICE bits per clock,
// start/busy/done handshake, registered result and zero flag.
module logic_unit_lane (
   input  logic [2:0] op,
   input  logic       a,
   input  logic       b,
   output logic       y
);
   always_comb begin
      y = 1'b0;
      case (op)
         3'b000: y = a & b;
         3'b001: y = a | b;
         3'b010: y = a ^ b;
         3'b011: y = ~(a & b);
         3'b100: y = ~(a | b);
         3'b101: y = ~(a ^ b);
         3'b110: y = ~a;
         3'b111: y = b;
         default: y = 1'b0;
      endcase
   end
endmodule

module logic_unit_seq #(
   parameter int WIDTH = 8,
   parameter int SLICE = 1
) (
   input logic             clk,
   input logic             rst_n,
   logic_unit_seq_if.slave bus
);
   localparam int N  = WIDTH / SLICE;
   localparam int CW = (N > 1) ? $clog2(N) : 1;

   generate
      if (WIDTH < 2 || SLICE < 1 || (WIDTH % SLICE) != 0) begin : g_bad_params
         $error("logic_unit_seq: WIDTH must be >= 2 and a multiple of SLICE");
      end
   endgenerate

   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

   state_t           state, state_nxt;
   logic [WIDTH-1:0] a_q, b_q, acc, acc_nxt;
   logic [2:0]       op_q;
   logic [CW-1:0]    cnt;
   logic [SLICE-1:0] slice_y;
   logic             last, accept;

   assign last   = (cnt == CW'(N - 1));
   assign accept = bus.start && (state != BUSY);

   // Operands shift right each cycle, so the lanes always see the LSB slice.
   for (genvar i = 0; i < SLICE; i++) begin : g_lane
      logic_unit_lane u_lane (.op(op_q), .a(a_q[i]), .b(b_q[i]), .y(slice_y[i]));
   end

   // Fresh slices enter at the top; after N shifts the first slice sits at bit 0.
   always_comb begin
      acc_nxt = acc >> SLICE;
      acc_nxt[WIDTH-1 -: SLICE] = slice_y;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (bus.start) state_nxt = BUSY;
         BUSY:    if (last) state_nxt = DONE;
         DONE:    state_nxt = bus.start ? BUSY : IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_q        <= '0;
         b_q        <= '0;
         op_q       <= '0;
         acc        <= '0;
         cnt        <= '0;
         bus.result <= '0;
         bus.zero   <= 1'b1;
      end else if (accept) begin
         a_q  <= bus.a;
         b_q  <= bus.b;
         op_q <= bus.op;
         acc  <= '0;
         cnt  <= '0;
      end else if (state == BUSY) begin
         a_q <= a_q >> SLICE;
         b_q <= b_q >> SLICE;
         acc <= acc_nxt;
         cnt <= cnt + CW'(1);
         if (last) begin
            bus.result <= acc_nxt;
            bus.zero   <= (acc_nxt == '0);
         end
      end
   end

   assign bus.busy = (state == BUSY);
   assign bus.done = (state == DONE);
endmodule

// File: tb/tb_logic_unit_seq.sv
// Bench for logic_unit_seq: an 8-bit/1-bit-slice and a 16-bit/4-bit-slice
// instance driven with directed and random operations against a vector model.
module tb_logic_unit_seq;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   logic_unit_seq_if #(.WIDTH(8))  if8 ();
   logic_unit_seq_if #(.WIDTH(16)) if16 ();

   logic_unit_seq #(.WIDTH(8),  .SLICE(1)) u_dut8  (.clk(clk), .rst_n(rst_n), .bus(if8));
   logic_unit_seq #(.WIDTH(16), .SLICE(4)) u_dut16 (.clk(clk), .rst_n(rst_n), .bus(if16));

   int n_cmp = 0;
   int n_err = 0;
   bit sel = 1'b0;

   logic        cur_busy, cur_done, cur_zero;
   logic [15:0] cur_res;
   assign cur_busy = sel ? if16.busy   : if8.busy;
   assign cur_done = sel ? if16.done   : if8.done;
   assign cur_zero = sel ? if16.zero   : if8.zero;
   assign cur_res  = sel ? if16.result : {8'h00, if8.result};

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [15:0] ref_op(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b);
      case (op)
         3'd0: return a & b;
         3'd1: return a | b;
         3'd2: return a ^ b;
         3'd3: return ~(a & b);
         3'd4: return ~(a | b);
         3'd5: return ~(a ^ b);
         3'd6: return ~a;
         default: return b;
      endcase
   endfunction

   task automatic drive(input logic s, input logic [2:0] op, input logic [15:0] a, input logic [15:0] b);
      if (sel) begin
         if16.start = s; if16.op = op; if16.a = a; if16.b = b;
      end else begin
         if8.start = s; if8.op = op; if8.a = a[7:0]; if8.b = b[7:0];
      end
   endtask

   // scr: scramble inputs during BUSY and pulse start at edge k+3.
   // from_done: caller is in the DONE cycle, so start is taken at the next edge.
   task automatic do_op(input bit s16, input logic [2:0] op, input logic [15:0] a, input logic [15:0] b,
                        input bit scr, input bit from_done, input bit idle_chk);
      int n;
      logic [15:0] exp;
      sel = s16;
      n   = s16 ? 4 : 8;
      exp = ref_op(op, a, b) & (s16 ? 16'hFFFF : 16'h00FF);
      if (!from_done) @(negedge clk);
      drive(1'b1, op, a, b);
      @(posedge clk); #1;
      drive(1'b0, op, a, b);
      chk("busy_after_start", cur_busy, 1);
      chk("done_after_start", cur_done, 0);
      for (int i = 1; i < n; i++) begin
         if (scr) drive(i == 3, 3'($urandom), 16'($urandom), 16'($urandom));
         @(posedge clk); #1;
         chk("busy_mid", cur_busy, 1);
         chk("done_mid", cur_done, 0);
      end
      if (scr) drive(1'b0, 3'($urandom), 16'($urandom), 16'($urandom));
      @(posedge clk); #1;
      chk("done_pulse", cur_done, 1);
      chk("busy_at_done", cur_busy, 0);
      chk("result", cur_res, exp);
      chk("zero", cur_zero, exp == 16'h0);
      if (idle_chk) begin
         @(posedge clk); #1;
         chk("done_drop", cur_done, 0);
         chk("busy_idle", cur_busy, 0);
         chk("result_hold", cur_res, exp);
      end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   initial begin
      sel = 1'b0; drive(1'b0, 3'd0, 16'h0, 16'h0);
      sel = 1'b1; drive(1'b0, 3'd0, 16'h0, 16'h0);
      repeat (3) @(posedge clk);
      #1;
      chk("rst_busy8", if8.busy, 0);
      chk("rst_done8", if8.done, 0);
      chk("rst_res8", if8.result, 0);
      chk("rst_zero8", if8.zero, 1);
      chk("rst_busy16", if16.busy, 0);
      chk("rst_res16", if16.result, 0);
      chk("rst_zero16", if16.zero, 1);
      @(negedge clk);
      rst_n = 1'b1;

      // 8-bit directed cases
      do_op(0, 3'd0, 16'hFF, 16'h00, 0, 0, 1);
      do_op(0, 3'd0, 16'hFF, 16'hA9, 1, 0, 1);
      do_op(0, 3'd0, 16'hFF, 16'hFF, 1, 0, 1);
      for (int o = 0; o < 8; o++) do_op(0, 3'(o), 16'hF0, 16'h3C, 0, 0, 1);

      // 16-bit: XOR then a back-to-back op with start held in DONE
      do_op(1, 3'd2, 16'h1234, 16'h0FF0, 0, 0, 0);
      do_op(1, 3'd4, 16'h00F0, 16'h0F00, 0, 1, 0);
      do_op(1, 3'd7, 16'hFFFF, 16'h8001, 1, 1, 1);

      // Asynchronous reset mid-operation on the 8-bit unit
      do_op(0, 3'd1, 16'h5A, 16'h81, 0, 0, 1);
      sel = 1'b0;
      @(negedge clk);
      drive(1'b1, 3'd0, 16'hFF, 16'h0F);
      @(posedge clk); #1;
      drive(1'b0, 3'd0, 16'hFF, 16'h0F);
      repeat (3) @(posedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      chk("arst_busy", cur_busy, 0);
      chk("arst_done", cur_done, 0);
      chk("arst_res", cur_res, 0);
      chk("arst_zero", cur_zero, 1);
      chk("arst_res16", if16.result, 0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 12; i++) begin
         @(posedge clk); #1;
         chk("no_done_after_rst", cur_done, 0);
      end
      do_op(0, 3'd5, 16'h3C, 16'hC3, 0, 0, 1);

      // Random operations on both units
      for (int i = 0; i < 40; i++)
         do_op(bit'($urandom_range(0, 1)), 3'($urandom), 16'($urandom), 16'($urandom),
               bit'($urandom_range(0, 1)), 0, 1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
